obi_sram_banked: RTL and testbench

- Parametrised dual-port OBI SRAM subsystem built from N sky130 1rw1r 32x512 macros.
- Port D is read/write; port I is read-only.
- Adds what the previous wrapper lacked: address-range checking with OBI error responses, write/read same-word conflict stalling on port I, a held read-data register per port, and saturating illegal-access counters.
- Sits between the core/data mux and the SRAM macros in the SoC memory map.

---
 rtl/obi_sram_pkg.sv | 38 +++
 rtl/obi_sram_port_ctrl.sv | 90 +++++++++
 rtl/obi_sram_banked.sv | 165 ++++++++++++++++
 tb/tb_obi_sram_banked.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_sram_pkg.sv
// Shared types and helpers for the banked OBI SRAM: address decode result,
// memory-size helper and the default error read data.
package obi_sram_pkg;

    localparam int unsigned BANK_SEL_W        = 5;
    localparam int unsigned WORD_MAX_W        = 16;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef struct packed {
        logic                  in_range;
        logic [BANK_SEL_W-1:0] bank;
        logic [WORD_MAX_W-1:0] word;
        logic                  err;
    } decode_t;

    function automatic logic [32:0] sram_bytes(input int unsigned num_banks,
                                               input int unsigned bank_aw);
        return 33'(num_banks) << (bank_aw + 2);
    endfunction

    // The offset wraps to a huge value below the base, so one unsigned compare covers both bounds.
    function automatic decode_t decode_addr(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned num_banks,
                                            input int unsigned bank_aw,
                                            input logic        we,
                                            input logic        writable);
        decode_t     dec;
        logic [31:0] off;
        off          = addr - base;
        dec.in_range = ({1'b0, off} < sram_bytes(num_banks, bank_aw));
        dec.bank     = BANK_SEL_W'(off >> (bank_aw + 2));
        dec.word     = WORD_MAX_W'((off >> 2) & ((32'd1 << bank_aw) - 32'd1));
        dec.err      = ~dec.in_range | (we & ~writable);
        return dec;
    endfunction

endpackage

// File: rtl/obi_sram_port_ctrl.sv
// One OBI port: decode, error detection, fixed-latency response, held read
// data and saturating illegal-access counter.
module obi_sram_port_ctrl
    import obi_sram_pkg::*;
#(
    parameter bit          WRITABLE  = 1'b1,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned NUM_BANKS = 24,
    parameter int unsigned BANK_AW   = 9,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 gnt_i,
    input  logic [31:0]          addr_i,
    input  logic                 we_i,
    input  logic                 clr_i,
    input  logic [31:0]          mem_rdata_i,
    output decode_t              dec_o,
    output logic                 mem_en_o,
    output logic [NUM_BANKS-1:0] bank_oh_o,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic                 err_event_o,
    output logic [CNT_W-1:0]     cnt_o
);

    logic                 granted;
    logic                 rvalid_d, rvalid_q;
    logic                 err_d, err_q;
    logic                 rd_d, rd_q;
    logic [NUM_BANKS-1:0] bank_oh_d, bank_oh_q;
    logic [31:0]          rdata_d, rdata_q;
    logic [CNT_W-1:0]     cnt_d, cnt_q;

    always_comb begin
        dec_o     = decode_addr(addr_i, BASE_ADDR, NUM_BANKS, BANK_AW, we_i, WRITABLE);
        granted   = req_i & gnt_i;
        mem_en_o  = granted & ~dec_o.err;
        rvalid_d  = granted;
        err_d     = granted & dec_o.err;
        rd_d      = mem_en_o & ~we_i;
        bank_oh_d = mem_en_o ? (NUM_BANKS'(1) << dec_o.bank) : '0;
    end

    // Read data is visible combinationally in the rvalid cycle and held afterwards.
    always_comb begin
        rdata_d = rdata_q;
        if (rvalid_q && err_q) begin
            rdata_d = ERR_RDATA;
        end else if (rvalid_q && rd_q) begin
            rdata_d = mem_rdata_i;
        end
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (err_d && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
            bank_oh_q <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
        end else begin
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
            bank_oh_q <= bank_oh_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_d;
    assign err_event_o = err_d;
    assign cnt_o       = cnt_q;
    assign bank_oh_o   = bank_oh_q;

endmodule

// File: rtl/obi_sram_banked.sv
// Dual-port OBI SRAM built from NUM_BANKS 1rw1r 32-bit macros: port D on the
// rw port, port I on the read port, with same-word write/read stalling.
module obi_sram_banked
    import obi_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned NUM_BANKS = 24,
    parameter int unsigned BANK_AW   = 9,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             d_req_i,
    output logic             d_gnt_o,
    input  logic [31:0]      d_addr_i,
    input  logic             d_we_i,
    input  logic [3:0]       d_be_i,
    input  logic [31:0]      d_wdata_i,
    output logic             d_rvalid_o,
    output logic [31:0]      d_rdata_o,
    output logic             d_err_o,
    input  logic             i_req_i,
    output logic             i_gnt_o,
    input  logic [31:0]      i_addr_i,
    input  logic             i_we_i,
    output logic             i_rvalid_o,
    output logic [31:0]      i_rdata_o,
    output logic             i_err_o,
    output logic             illegal_memory_o,
    input  logic             illegal_clr_i,
    output logic [CNT_W-1:0] d_illegal_cnt_o,
    output logic [CNT_W-1:0] i_illegal_cnt_o
);

    decode_t                     d_dec, i_dec;
    logic                        d_mem_en, i_mem_en;
    logic [NUM_BANKS-1:0]        d_bank_oh, i_bank_oh;
    logic                        d_err_evt, i_err_evt;
    logic [31:0]                 d_mem_rdata, i_mem_rdata;
    logic [NUM_BANKS-1:0][31:0]  d_dout_sel, i_dout_sel;
    logic                        conflict;
    logic                        illegal_memory_d, illegal_memory_q;

    // A same-word read during a write would return undefined macro data, so I waits.
    always_comb begin
        conflict = d_req_i & d_we_i & d_dec.in_range & i_dec.in_range
                 & (d_dec.bank == i_dec.bank) & (d_dec.word == i_dec.word);
        illegal_memory_d = illegal_clr_i ? 1'b0
                         : (illegal_memory_q | d_err_evt | i_err_evt);
    end

    assign d_gnt_o = d_req_i;
    assign i_gnt_o = i_req_i & ~conflict;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            illegal_memory_q <= 1'b0;
        end else begin
            illegal_memory_q <= illegal_memory_d;
        end
    end

    assign illegal_memory_o = illegal_memory_q;

    obi_sram_port_ctrl #(
        .WRITABLE (1'b1),
        .BASE_ADDR(BASE_ADDR),
        .NUM_BANKS(NUM_BANKS),
        .BANK_AW  (BANK_AW),
        .ERR_RDATA(ERR_RDATA),
        .CNT_W    (CNT_W)
    ) u_d_port (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (d_req_i),
        .gnt_i      (d_gnt_o),
        .addr_i     (d_addr_i),
        .we_i       (d_we_i),
        .clr_i      (illegal_clr_i),
        .mem_rdata_i(d_mem_rdata),
        .dec_o      (d_dec),
        .mem_en_o   (d_mem_en),
        .bank_oh_o  (d_bank_oh),
        .rvalid_o   (d_rvalid_o),
        .rdata_o    (d_rdata_o),
        .err_o      (d_err_o),
        .err_event_o(d_err_evt),
        .cnt_o      (d_illegal_cnt_o)
    );

    obi_sram_port_ctrl #(
        .WRITABLE (1'b0),
        .BASE_ADDR(BASE_ADDR),
        .NUM_BANKS(NUM_BANKS),
        .BANK_AW  (BANK_AW),
        .ERR_RDATA(ERR_RDATA),
        .CNT_W    (CNT_W)
    ) u_i_port (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (i_req_i),
        .gnt_i      (i_gnt_o),
        .addr_i     (i_addr_i),
        .we_i       (i_we_i),
        .clr_i      (illegal_clr_i),
        .mem_rdata_i(i_mem_rdata),
        .dec_o      (i_dec),
        .mem_en_o   (i_mem_en),
        .bank_oh_o  (i_bank_oh),
        .rvalid_o   (i_rvalid_o),
        .rdata_o    (i_rdata_o),
        .err_o      (i_err_o),
        .err_event_o(i_err_evt),
        .cnt_o      (i_illegal_cnt_o)
    );

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic               csb0, web0, csb1;
        logic [3:0]         wmask0;
        logic [BANK_AW-1:0] addr0, addr1;
        logic [31:0]        dout0_q, dout1_q;
        logic [31:0]        mem [2**BANK_AW];

        always_comb begin
            csb0   = ~(d_mem_en & (d_dec.bank == BANK_SEL_W'(gi)));
            web0   = ~d_we_i;
            wmask0 = d_be_i;
            addr0  = d_dec.word[BANK_AW-1:0];
            csb1   = ~(i_mem_en & (i_dec.bank == BANK_SEL_W'(gi)));
            addr1  = i_dec.word[BANK_AW-1:0];
        end

        // Behavioural 1rw1r macro: masked write on port 0, registered reads on both ports.
        always_ff @(posedge clk_i) begin
            if (!csb0) begin
                if (!web0) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wmask0[b]) begin
                            mem[addr0][b*8 +: 8] <= d_wdata_i[b*8 +: 8];
                        end
                    end
                end else begin
                    dout0_q <= mem[addr0];
                end
            end
            if (!csb1) begin
                dout1_q <= mem[addr1];
            end
        end

        assign d_dout_sel[gi] = d_bank_oh[gi] ? dout0_q : '0;
        assign i_dout_sel[gi] = i_bank_oh[gi] ? dout1_q : '0;
    end

    always_comb begin
        d_mem_rdata = '0;
        i_mem_rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            d_mem_rdata = d_mem_rdata | d_dout_sel[b];
            i_mem_rdata = i_mem_rdata | i_dout_sel[b];
        end
    end

endmodule

// File: tb/tb_obi_sram_banked.sv
// Self-checking bench for obi_sram_banked: directed scenarios followed by
// randomized dual-port traffic against a word-array reference model.
module tb_obi_sram_banked;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          NB   = 24;
    localparam int          AW   = 9;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    localparam int          CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          d_req_i = 1'b0, d_we_i = 1'b0;
    logic [31:0]   d_addr_i = '0, d_wdata_i = '0;
    logic [3:0]    d_be_i = '0;
    logic          d_gnt_o, d_rvalid_o, d_err_o;
    logic [31:0]   d_rdata_o;
    logic          i_req_i = 1'b0, i_we_i = 1'b0;
    logic [31:0]   i_addr_i = '0;
    logic          i_gnt_o, i_rvalid_o, i_err_o;
    logic [31:0]   i_rdata_o;
    logic          illegal_memory_o;
    logic          illegal_clr_i = 1'b0;
    logic [CW-1:0] d_illegal_cnt_o, i_illegal_cnt_o;

    always #5 clk_i = ~clk_i;

    obi_sram_banked #(.CNT_W(CW)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .d_req_i         (d_req_i),
        .d_gnt_o         (d_gnt_o),
        .d_addr_i        (d_addr_i),
        .d_we_i          (d_we_i),
        .d_be_i          (d_be_i),
        .d_wdata_i       (d_wdata_i),
        .d_rvalid_o      (d_rvalid_o),
        .d_rdata_o       (d_rdata_o),
        .d_err_o         (d_err_o),
        .i_req_i         (i_req_i),
        .i_gnt_o         (i_gnt_o),
        .i_addr_i        (i_addr_i),
        .i_we_i          (i_we_i),
        .i_rvalid_o      (i_rvalid_o),
        .i_rdata_o       (i_rdata_o),
        .i_err_o         (i_err_o),
        .illegal_memory_o(illegal_memory_o),
        .illegal_clr_i   (illegal_clr_i),
        .d_illegal_cnt_o (d_illegal_cnt_o),
        .i_illegal_cnt_o (i_illegal_cnt_o)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mdl [int];
    logic [31:0] d_last = '0, i_last = '0;
    int          d_cnt = 0, i_cnt = 0;
    bit          flag = 1'b0;
    bit          last_i_gnt = 1'b0;
    logic [31:0] pool [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        logic [63:0] a64, lo, hi;
        a64 = {32'd0, a};
        lo  = {32'd0, BASE};
        hi  = lo + 64'(NB) * 64'(1 << (AW + 2));
        return (a64 >= lo) && (a64 < hi);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return int'(off);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    // One bus cycle: drive both ports, check grants, predict and check the responses.
    task automatic cycle(input bit dr, input logic [31:0] da, input bit dw,
                         input logic [3:0] dbe, input logic [31:0] dwd,
                         input bit ir, input logic [31:0] ia, input bit iw, input bit clr);
        bit conf, dg, ig, derr, ierr;
        d_req_i = dr; d_addr_i = da; d_we_i = dw; d_be_i = dbe; d_wdata_i = dwd;
        i_req_i = ir; i_addr_i = ia; i_we_i = iw; illegal_clr_i = clr;
        #1;
        conf = dr && dw && in_rng(da) && in_rng(ia) && (widx(da) == widx(ia));
        dg   = dr;
        ig   = ir && !conf;
        chk("d_gnt", d_gnt_o, dg);
        chk("i_gnt", i_gnt_o, ig);
        last_i_gnt = ig;
        derr = dg && !in_rng(da);
        ierr = ig && (!in_rng(ia) || iw);
        if (derr) d_last = ERRD;
        else if (dg && !dw) d_last = mdl[widx(da)];
        if (ierr) i_last = ERRD;
        else if (ig) i_last = mdl[widx(ia)];
        if (dg && dw && !derr) mdl[widx(da)] = merge(mdl[widx(da)], dwd, dbe);
        if (clr) begin
            d_cnt = 0; i_cnt = 0; flag = 1'b0;
        end else begin
            if (derr) begin flag = 1'b1; if (d_cnt < CMAX) d_cnt++; end
            if (ierr) begin flag = 1'b1; if (i_cnt < CMAX) i_cnt++; end
        end
        @(posedge clk_i); #1;
        chk("d_rvalid", d_rvalid_o, dg);
        if (dg) chk("d_err", d_err_o, derr);
        chk("d_rdata", d_rdata_o, d_last);
        chk("i_rvalid", i_rvalid_o, ig);
        if (ig) chk("i_err", i_err_o, ierr);
        chk("i_rdata", i_rdata_o, i_last);
        chk("d_cnt", 32'(d_illegal_cnt_o), d_cnt);
        chk("i_cnt", 32'(i_illegal_cnt_o), i_cnt);
        chk("illegal", illegal_memory_o, flag);
        $display("[TB] t=%0t D(req=%0b we=%0b a=%h) I(req=%0b we=%0b a=%h) clr=%0b", $time,
                 dr, dw, da, ir, iw, ia, clr);
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h8000_C000 + ($urandom_range(0, 15) << 2);
        if (r == 1) return BASE - ($urandom_range(1, 8) << 2);
        return pool[$urandom_range(0, 15)] | 32'($urandom_range(0, 3));
    endfunction

    bit          r_dr, r_dw, r_ir, r_iw, r_clr, i_pend;
    logic [31:0] r_da, r_ia;

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_d_rvalid", d_rvalid_o, 1'b0);
        chk("rst_i_rvalid", i_rvalid_o, 1'b0);
        chk("rst_d_err", d_err_o, 1'b0);
        chk("rst_i_err", i_err_o, 1'b0);
        chk("rst_d_rdata", d_rdata_o, 32'h0);
        chk("rst_i_rdata", i_rdata_o, 32'h0);
        chk("rst_illegal", illegal_memory_o, 1'b0);
        chk("rst_d_cnt", 32'(d_illegal_cnt_o), 0);
        chk("rst_i_cnt", 32'(i_illegal_cnt_o), 0);
        rst_ni = 1'b1;

        pool[0] = 32'h8000_0010; pool[1] = 32'h8000_2004; pool[2] = 32'h8000_2008;
        pool[3] = BASE;          pool[4] = 32'h8000_BFFC; pool[5] = 32'h8000_0800;
        for (int k = 6; k < 16; k++) pool[k] = BASE + ($urandom_range(0, NB * 512 - 1) << 2);
        for (int k = 0; k < 16; k++) cycle(1, pool[k], 1, 4'hF, $urandom, 0, BASE, 0, 0);

        // Write then read through port I
        cycle(1, 32'h8000_0010, 1, 4'hF, 32'hCAFE_F00D, 0, BASE, 0, 0);
        chk("wr_no_err", d_err_o, 1'b0);
        cycle(0, BASE, 0, 4'h0, 0, 1, 32'h8000_0010, 0, 0);
        chk("i_rd_cafe", i_rdata_o, 32'hCAFE_F00D);

        // Partial byte write
        cycle(1, pool[5], 1, 4'hF, 32'h1122_3344, 0, BASE, 0, 0);
        cycle(1, pool[5], 1, 4'b0010, 32'h0000_AB00, 0, BASE, 0, 0);
        cycle(1, pool[5], 0, 4'hF, 0, 0, BASE, 0, 0);
        chk("partial_merge", d_rdata_o, 32'h1122_AB44);

        // One past the end and one below the base
        cycle(1, 32'h8000_C000, 0, 4'hF, 0, 0, BASE, 0, 0);
        chk("oor_err", d_err_o, 1'b1);
        chk("oor_rdata", d_rdata_o, 32'hDEAD_BEEF);
        chk("oor_cnt", 32'(d_illegal_cnt_o), 1);
        chk("oor_flag", illegal_memory_o, 1'b1);
        cycle(1, 32'h7FFF_FFFC, 0, 4'hF, 0, 1, 32'h8000_BFFC, 0, 0);

        // Same-word conflict, then same bank different word
        cycle(1, 32'h8000_2004, 1, 4'hF, 32'h5A5A_1234, 1, 32'h8000_2004, 0, 0);
        cycle(0, BASE, 0, 4'h0, 0, 1, 32'h8000_2004, 0, 0);
        chk("i_new_data", i_rdata_o, 32'h5A5A_1234);
        cycle(1, 32'h8000_2004, 1, 4'hF, 32'h0BAD_CAFE, 1, 32'h8000_2008, 0, 0);

        // Writes on port I, then clear racing an error
        cycle(0, BASE, 0, 4'h0, 0, 1, 32'h8000_2008, 1, 0);
        chk("i_we_err", i_err_o, 1'b1);
        cycle(1, 32'h8000_2008, 0, 4'hF, 0, 0, BASE, 0, 0);
        cycle(1, 32'h8000_C004, 0, 4'hF, 0, 1, BASE, 1, 1);
        chk("clr_prio_d", 32'(d_illegal_cnt_o), 0);
        chk("clr_prio_i", 32'(i_illegal_cnt_o), 0);
        chk("clr_prio_flag", illegal_memory_o, 1'b0);

        // Counter saturation
        repeat (CMAX + 3) cycle(1, 32'h8000_C000, 0, 4'hF, 0, 1, BASE, 1, 0);
        chk("d_sat", 32'(d_illegal_cnt_o), CMAX);
        chk("i_sat", 32'(i_illegal_cnt_o), CMAX);

        // Reset during the response cycle of a read, with a new read also requested
        cycle(1, pool[3], 0, 4'hF, 0, 0, BASE, 0, 0);
        rst_ni = 1'b0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = pool[4]; i_req_i = 1'b0; illegal_clr_i = 1'b0;
        @(posedge clk_i); #1;
        chk("rst_drop_rvalid", d_rvalid_o, 1'b0);
        chk("rst_drop_d_cnt", 32'(d_illegal_cnt_o), 0);
        chk("rst_drop_i_cnt", 32'(i_illegal_cnt_o), 0);
        chk("rst_drop_flag", illegal_memory_o, 1'b0);
        chk("rst_drop_rdata", d_rdata_o, 32'h0);
        rst_ni = 1'b1;
        d_last = '0; i_last = '0; d_cnt = 0; i_cnt = 0; flag = 1'b0;
        cycle(0, BASE, 0, 4'h0, 0, 0, BASE, 0, 0);

        // Randomized dual-port traffic; a stalled I request is held unchanged
        i_pend = 1'b0;
        for (int n = 0; n < 600; n++) begin
            r_dr = ($urandom_range(0, 3) != 0);
            r_dw = $urandom_range(0, 1) == 1;
            r_da = pick_addr();
            if (!i_pend) begin
                r_ir = ($urandom_range(0, 2) != 0);
                r_ia = pick_addr();
                r_iw = ($urandom_range(0, 9) == 0);
            end
            if (r_ir && $urandom_range(0, 4) == 0) r_da = r_ia;
            r_clr = ($urandom_range(0, 39) == 0);
            cycle(r_dr, r_da, r_dw, 4'($urandom), $urandom, r_ir, r_ia, r_iw, r_clr);
            i_pend = r_ir && !last_i_gnt;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
